// File: rtl/xup_debounce_pkg.sv
// Shared constants and channel state encoding for the six-channel debouncer.
package xup_debounce_pkg;
  localparam int DEF_TICK_DIV     = 100000;
  localparam int DEF_STABLE_TICKS = 10;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;
endpackage

// File: rtl/xup_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, tick-counted acceptance of a new
// level, and one-cycle rise/fall pulses on each accepted change.
module xup_debounce_ch
  import xup_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_dout, r_rise, r_fall;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_dout_nxt, w_rise_nxt, w_fall_nxt;
  db_state_e     w_state;

  // The channel is pending exactly while the synchronized input disagrees
  // with the accepted level; a bounce back drops the count in the same cycle.
  always_comb begin
    w_state    = (r_sync[1] != r_dout) ? PENDING : STABLE;
    w_cnt_nxt  = '0;
    w_dout_nxt = r_dout;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    case (w_state)
      STABLE: ;
      PENDING: begin
        if (!tick) begin
          w_cnt_nxt = r_cnt;
        end else if (r_cnt == CW'(STABLE_TICKS - 1)) begin
          w_dout_nxt = r_sync[1];
          w_rise_nxt = r_sync[1];
          w_fall_nxt = ~r_sync[1];
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_dout <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], din};
      r_cnt  <= w_cnt_nxt;
      r_dout <= w_dout_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
endmodule

// File: rtl/xup_debounce6.sv
// Six-channel switch/button conditioner: shared sample-tick prescaler feeding
// WIDTH independent debounce channels.
module xup_debounce6
  import xup_debounce_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int WIDTH        = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);
  localparam int PW = $clog2(TICK_DIV);

  generate
    if (TICK_DIV < 2 || STABLE_TICKS < 1) begin : g_bad_param
      $error("xup_debounce6: TICK_DIV must be >= 2 and STABLE_TICKS >= 1");
    end
  endgenerate

  logic [PW-1:0] r_pre;
  logic          r_tick;

  // Tick is registered one count early so it is high exactly while the
  // prescaler sits at TICK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= (r_pre == PW'(TICK_DIV - 1)) ? '0 : r_pre + PW'(1);
      r_tick <= (r_pre == PW'(TICK_DIV - 2));
    end
  end

  assign tick = r_tick;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    xup_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .tick (r_tick),
      .din  (din[g]),
      .dout (dout[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end
endmodule

// File: tb/tb_xup_debounce6.sv
// Bench for xup_debounce6 at TICK_DIV=4, STABLE_TICKS=3: directed sequences,
// a vector table, and random stimulus against a tick-counting reference model.
module tb_xup_debounce6;
  localparam int TD = 4;
  localparam int ST = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] din;
  logic [5:0] dout, rise, fall;
  logic       tick;
  logic [18:0] outs;

  assign outs = {dout, rise, fall, tick};

  xup_debounce6 #(.TICK_DIV(TD), .STABLE_TICKS(ST), .WIDTH(6)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .tick (tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: cycle index since reset release, a 2-deep input delay,
  // and for each channel the cycle at which its current disagreement began.
  logic [5:0] m_s1, m_s2, m_dout, m_rise, m_fall;
  logic       m_tick;
  int         m_c;
  int         m_start[6];

  typedef struct {
    logic [5:0] din;
    int         hold;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
    n_chk++;
    if (v >= lo && v <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", nm, v, lo, hi);
  endtask

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_dout = '0; m_rise = '0; m_fall = '0;
    m_tick = 1'b0; m_c = 0;
    for (int i = 0; i < 6; i++) m_start[i] = -1;
  endtask

  // A channel commits on a tick cycle when the number of tick cycles in its
  // unbroken disagreement run (inclusive) reaches ST.
  task automatic model_edge();
    bit tk;
    int n;
    tk = ((m_c % TD) == TD - 1);
    for (int i = 0; i < 6; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (m_s2[i] != m_dout[i]) begin
        if (m_start[i] < 0) m_start[i] = m_c;
        n = (m_c + 1) / TD - m_start[i] / TD;
        if (tk && n == ST) begin
          m_dout[i]  = m_s2[i];
          m_rise[i]  = m_s2[i];
          m_fall[i]  = ~m_s2[i];
          m_start[i] = -1;
        end
      end else begin
        m_start[i] = -1;
      end
    end
    m_s2 = m_s1;
    m_s1 = din;
    m_c++;
    m_tick = ((m_c % TD) == TD - 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", outs, {m_dout, m_rise, m_fall, m_tick});
  endtask

  task automatic do_reset(input logic [5:0] d, input int hold);
    reset = 1'b1;
    din   = d;
    m_reset();
    #1;
    chk("rst_async", outs, 19'h0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("rst_hold", outs, 19'h0);
    end
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, rc, fc, ft;
    logic [5:0] acc;
    int tq[$];
    int hold[6];

    vecs[0] = '{6'h01, 16, 6'h01};
    vecs[1] = '{6'h21, 16, 6'h21};
    vecs[2] = '{6'h3F,  3, 6'h21};
    vecs[3] = '{6'h21, 16, 6'h21};
    vecs[4] = '{6'h00, 16, 6'h00};
    vecs[5] = '{6'h2A, 16, 6'h2A};
    vecs[6] = '{6'h15,  2, 6'h2A};
    vecs[7] = '{6'h15, 16, 6'h15};
    vecs[8] = '{6'h3F, 16, 6'h3F};

    reset = 1'b1;
    din   = '0;

    // Reset with all inputs high, then tick cadence after release.
    do_reset(6'h3F, 4);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (tick) tq.push_back(k);
    end
    ft = (tq.size() > 0) ? tq[0] : 0;
    chk("tick_count", tq.size(), 3);
    chk("tick_first", ft, 3);
    chk("tick_period", (tq.size() == 3) ? (tq[2] - tq[1]) * 10 + (tq[1] - tq[0]) : 0, 44);

    // Clean press on channel 0.
    do_reset(6'h00, 2);
    repeat (3) step();
    din[0] = 1'b1;
    n = 0; rc = 0; fc = 0; acc = '0;
    for (int k = 1; k <= 40; k++) begin
      step();
      rc += int'(rise[0]); fc += int'(fall[0]); acc |= {dout[5:1], 1'b0};
      if (dout[0] && n == 0) n = k;
      if (n != 0 && k >= n + 3) break;
    end
    chk_rng("press_lat", n, 11, 14);
    chk("press_rise", rc, 1);
    chk("press_fall", fc, 0);
    chk("press_other", acc, 6'h00);

    // Bounce on channel 2, then held high.
    acc = '0; rc = 0;
    for (int t = 0; t < 4; t++) begin
      din[2] = (t % 2 == 0);
      repeat (5) begin
        step();
        acc[2] = acc[2] | dout[2];
        rc += int'(rise[2]);
      end
    end
    chk("bounce_hold", acc, 6'h00);
    din[2] = 1'b1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      rc += int'(rise[2]);
      if (dout[2] && n == 0) n = k;
      if (n != 0 && k >= n + 3) break;
    end
    chk_rng("bounce_lat", n, 11, 14);
    chk("bounce_rise", rc, 1);

    // Release on channel 5.
    din[5] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (dout[5]) break;
    end
    chk("rel_accept", dout[5], 1'b1);
    din[5] = 1'b0;
    n = 0; fc = 0; rc = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      fc += int'(fall[5]); rc += int'(rise[5]);
      if (!dout[5] && n == 0) n = k;
      if (n != 0 && k >= n + 3) break;
    end
    chk_rng("rel_lat", n, 11, 14);
    chk("rel_fall", fc, 1);
    chk("rel_rise", rc, 0);

    // Simultaneous commit on three channels.
    do_reset(6'h00, 2);
    repeat (2) step();
    din = 6'h2A;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (dout != 6'h00) break;
    end
    chk("sim_dout", dout, 6'h2A);
    chk("sim_rise", rise, 6'h2A);
    step();
    chk("sim_rise_clr", rise, 6'h00);

    // Reset in the middle of a pending run restarts the full debounce.
    do_reset(6'h00, 2);
    din[1] = 1'b1;
    repeat (10) step();
    chk("midrst_pre", dout[1], 1'b0);
    do_reset(6'h02, 1);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (dout[1]) begin
        n = k;
        break;
      end
    end
    chk("midrst_lat", n, 12);

    // Vector table.
    do_reset(6'h00, 2);
    for (int i = 0; i < 9; i++) begin
      din = vecs[i].din;
      repeat (vecs[i].hold) step();
      chk($sformatf("vec%0d", i), dout, vecs[i].exp);
    end

    // Random stimulus with occasional resets.
    do_reset(6'h00, 2);
    for (int i = 0; i < 6; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      for (int i = 0; i < 6; i++) begin
        if (hold[i] == 0) begin
          if ($urandom_range(0, 1) == 1) din[i] = ~din[i];
          hold[i] = $urandom_range(1, 18);
        end else begin
          hold[i]--;
        end
      end
      if ($urandom_range(0, 299) == 0) do_reset(din, 1);
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
